// File: rtl/contador_seq_checker.sv
// Sequence checker for the arbitrary-sequence counter: hunts, locks, predicts Q.
// Optional CONTADOR_AUTO_RESYNC_EN: ERROR lasts one cycle, then returns to HUNT.
module contador_seq_checker #(
    parameter int              W     = 4,
    parameter int              LEN   = 8,
    parameter logic [W*LEN-1:0] SEQ  = {4'd14, 4'd13, 4'd11, 4'd8,
                                        4'd7, 4'd5, 4'd2, 4'd0},
    parameter int              CNT_W = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic [W-1:0]     Q,
    output logic             sync,
    output logic             err,
    output logic [W-1:0]     expected,
    output logic [CNT_W-1:0] laps,
    output logic [CNT_W-1:0] errors
);

    localparam int            IW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(LEN - 1);

    typedef enum logic [1:0] {HUNT, LOCK, ERROR} state_t;

    state_t             state;
    state_t             state_nx;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      idx_nx;
    logic [W-1:0]       exp_nx;
    logic [CNT_W-1:0]   laps_nx;
    logic [CNT_W-1:0]   errors_nx;
    logic               err_nx;
    logic               sync_nx;
    logic               hit;
    logic [IW-1:0]      hit_k;

    function automatic logic [W-1:0] entry(input logic [IW-1:0] i);
        return SEQ[W*int'(i) +: W];
    endfunction

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] i);
        return (i == LAST) ? '0 : i + 1'b1;
    endfunction

    // Downward scan so the lowest matching entry wins.
    always_comb begin
        hit   = 1'b0;
        hit_k = '0;
        for (int k = LEN - 1; k >= 0; k--) begin
            if (Q == entry(IW'(k))) begin
                hit   = 1'b1;
                hit_k = IW'(k);
            end
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            state <= HUNT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            HUNT: begin
                if (hit) state_nx = LOCK;
            end
            LOCK: begin
                if (Q != expected) state_nx = ERROR;
            end
            ERROR: begin
`ifdef CONTADOR_AUTO_RESYNC_EN
                state_nx = HUNT;
`else
                state_nx = ERROR;
`endif
            end
            default: state_nx = HUNT;
        endcase
    end

    always_comb begin
        idx_nx    = idx;
        exp_nx    = expected;
        laps_nx   = laps;
        errors_nx = errors;
        err_nx    = 1'b0;
        unique case (state)
            HUNT: begin
                if (hit) begin
                    idx_nx = wrap(hit_k);
                    exp_nx = entry(idx_nx);
                end
            end
            LOCK: begin
                if (Q == expected) begin
                    idx_nx = wrap(idx);
                    exp_nx = entry(idx_nx);
                    if (idx == LAST) laps_nx = laps + 1'b1;
                end else begin
                    err_nx = 1'b1;
                    if (errors != '1) errors_nx = errors + 1'b1;
                end
            end
            default: ;
        endcase
        sync_nx = (state_nx == LOCK);
    end

    always_ff @(posedge C) begin
        if (R) begin
            idx      <= '0;
            expected <= entry('0);
            laps     <= '0;
            errors   <= '0;
            err      <= 1'b0;
            sync     <= 1'b0;
        end else begin
            idx      <= idx_nx;
            expected <= exp_nx;
            laps     <= laps_nx;
            errors   <= errors_nx;
            err      <= err_nx;
            sync     <= sync_nx;
        end
    end

endmodule

// File: tb/tb_contador_seq_checker.sv
// Randomized and directed bench for contador_seq_checker against a
// sequence-position reference model.
module tb_contador_seq_checker;

    logic       clk;
    logic       rst;
    logic [3:0] q;
    logic       sync;
    logic       err;
    logic [3:0] expected;
    logic [7:0] laps;
    logic [7:0] errors;

    int seq_tab[8] = '{0, 2, 5, 7, 8, 11, 13, 14};

    // model: mode 0=hunt 1=lock 2=error
    int m_mode;
    int m_pos;
    int m_laps;
    int m_errs;
    int m_err;

    int n_checks;
    int n_pass;

    contador_seq_checker dut (
        .C        (clk),
        .R        (rst),
        .Q        (q),
        .sync     (sync),
        .err      (err),
        .expected (expected),
        .laps     (laps),
        .errors   (errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    function automatic int find_entry(input int v);
        for (int k = 0; k < 8; k++) begin
            if (seq_tab[k] == v) return k;
        end
        return -1;
    endfunction

    task automatic model_edge(input int v, input bit r);
        int k;
        m_err = 0;
        if (r) begin
            m_mode = 0;
            m_pos  = 0;
            m_laps = 0;
            m_errs = 0;
        end else if (m_mode == 0) begin
            k = find_entry(v);
            if (k >= 0) begin
                m_mode = 1;
                m_pos  = (k + 1) % 8;
            end
        end else if (m_mode == 1) begin
            if (v == seq_tab[m_pos]) begin
                if (m_pos == 7) m_laps = (m_laps + 1) % 256;
                m_pos = (m_pos + 1) % 8;
            end else begin
                m_err  = 1;
                m_errs = (m_errs < 255) ? m_errs + 1 : 255;
                m_mode = 2;
            end
        end else begin
`ifdef CONTADOR_AUTO_RESYNC_EN
            m_mode = 0;
`endif
        end
    endtask

    task automatic step(input int v, input bit r);
        q   = 4'(v);
        rst = r;
        @(posedge clk);
        model_edge(v, r);
        #1;
        chk("sync", int'(sync), (m_mode == 1) ? 1 : 0);
        chk("err", int'(err), m_err);
        chk("expected", int'(expected), seq_tab[m_pos]);
        chk("laps", int'(laps), m_laps);
        chk("errors", int'(errors), m_errs);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(0, 1'b1);
    endtask

    initial begin
        int v;
        n_checks = 0;
        n_pass   = 0;
        m_mode   = 0;
        m_pos    = 0;
        m_laps   = 0;
        m_errs   = 0;
        m_err    = 0;
        q        = '0;
        rst      = 1'b1;
        #2;

        // 1: full lap
        do_reset(2);
        chk("rst_sync", int'(sync), 0);
        chk("rst_exp", int'(expected), 0);
        chk("rst_laps", int'(laps), 0);
        foreach (seq_tab[i]) step(seq_tab[i], 1'b0);
        chk("t1_laps_pre", int'(laps), 1);
        step(0, 1'b0);
        chk("t1_laps", int'(laps), 1);
        chk("t1_exp", int'(expected), 2);
        chk("t1_sync", int'(sync), 1);

        // 2: mid-sequence lock
        do_reset(1);
        step(7, 1'b0);
        chk("t2_exp8", int'(expected), 8);
        step(8, 1'b0);
        step(11, 1'b0);
        chk("t2_exp13", int'(expected), 13);
        chk("t2_sync", int'(sync), 1);
        chk("t2_errs", int'(errors), 0);

        // 3: non-members
        do_reset(1);
        step(1, 1'b0);
        step(3, 1'b0);
        step(4, 1'b0);
        step(15, 1'b0);
        chk("t3_sync", int'(sync), 0);
        chk("t3_exp", int'(expected), 0);

        // 4: mismatch
        do_reset(1);
        step(0, 1'b0);
        step(2, 1'b0);
        step(6, 1'b0);
        chk("t4_err", int'(err), 1);
        chk("t4_errs", int'(errors), 1);
        chk("t4_sync", int'(sync), 0);
        step(0, 1'b0);
        chk("t4_err_once", int'(err), 0);
        step(2, 1'b0);
        step(5, 1'b0);
`ifdef CONTADOR_AUTO_RESYNC_EN
        chk("t4_relock", int'(sync), 1);
        chk("t4_relock_exp", int'(expected), 7);
`else
        chk("t4_terminal", int'(sync), 0);
        chk("t4_held_exp", int'(expected), 5);
        chk("t4_frozen", int'(errors), 1);
`endif

`ifdef CONTADOR_AUTO_RESYNC_EN
        // 5: saturation
        do_reset(1);
        for (int i = 0; i < 300; i++) begin
            step(0, 1'b0);
            step(6, 1'b0);
            chk("t5_pulse", int'(err), 1);
            step(1, 1'b0);
        end
        chk("t5_sat", int'(errors), 255);
`endif

        // 6: reset mid-operation
        do_reset(1);
`ifdef CONTADOR_AUTO_RESYNC_EN
        for (int i = 0; i < 2; i++) begin
            step(0, 1'b0);
            step(6, 1'b0);
            step(1, 1'b0);
        end
`endif
        for (int i = 0; i < 25; i++) step(seq_tab[i % 8], 1'b0);
        chk("t6_laps3", int'(laps), 3);
`ifdef CONTADOR_AUTO_RESYNC_EN
        chk("t6_errs2", int'(errors), 2);
`endif
        step(0, 1'b1);
        chk("t6_sync", int'(sync), 0);
        chk("t6_err", int'(err), 0);
        chk("t6_exp", int'(expected), 0);
        chk("t6_laps", int'(laps), 0);
        chk("t6_errs", int'(errors), 0);

        // random traffic, biased toward the predicted value
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 75 && m_mode == 1) begin
                v = seq_tab[m_pos];
            end else begin
                v = int'($urandom_range(15));
            end
            step(v, ($urandom_range(99) < 3) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/contador_seq_checker.md
Name: contador_seq_checker

Overview:
- Monitors the 4-bit Q output of the arbitrary-sequence counter and checks that it follows the programmed arbitrary sequence.
- Acquires lock on any sequence member, then predicts and checks every following sample.
- Flags deviations and keeps counts of completed sequence laps and of errors.
- Sits beside the counter in the test environment and in top-level builds, fed directly from the counter's Q.

Parameters:
- W, 4, width of monitored value.
- LEN, 8, number of sequence entries (1..16).
- SEQ, {4'd14,4'd13,4'd11,4'd8,4'd7,4'd5,4'd2,4'd0}, packed sequence; entry k occupies bits [W*k+W-1:W*k]; default order 0,2,5,7,8,11,13,14; entries must be distinct (duplicates: behaviour undefined).
- CNT_W, 8, width of the lap and error counters.

Ports:
- C  input  1  clock; all state updates on the rising edge.
- R  input  1  synchronous reset, active-high.
- Q  input  W  counter value under observation, sampled every rising edge of C.
- sync  output  1  1 while in LOCK.
- err  output  1  one-cycle pulse on each detected mismatch.
- expected  output  W  next value predicted in LOCK.
- laps  output  CNT_W  completed full sequences, wraps modulo 2^CNT_W.
- errors  output  CNT_W  mismatch count, saturates at all-ones.

Behaviour:
- Clocking and reset:
  - Single clock C; R is synchronous, active-high, and has priority over every other event.
  - Reset values: state=HUNT, idx=0, sync=0, err=0, expected=SEQ[0], laps=0, errors=0.
  - All outputs are registered; response appears one edge after the sample that caused it.
- States: HUNT, LOCK, ERROR.
- HUNT:
  - Q equal to entry k: go to LOCK, idx=(k+1) mod LEN, expected=SEQ[idx].
  - No entry matches: stay in HUNT, err=0, no counter change.
  - The lowest matching k wins; with distinct entries only one can match.
- LOCK, Q==expected:
  - idx advances modulo LEN and expected updates.
  - If the accepted entry was SEQ[LEN-1], laps increments.
- LOCK, Q!=expected:
  - err=1 for exactly one cycle.
  - errors increments, saturating at 2^CNT_W-1.
  - sync=0, go to ERROR.
- ERROR: see Optional Feature.
- err is 0 in every cycle that does not record a mismatch.
- LEN=1: every sample equal to SEQ[0] in LOCK increments laps.
- Wrap-around: after SEQ[LEN-1], expected returns to SEQ[0].
- R asserted in any state, including mid-LOCK: reset values appear at the next edge; no err pulse, no count update in that cycle.
- Q width mismatch is not permitted; Q is compared across all W bits.

Optional Feature:
- Macro: CONTADOR_AUTO_RESYNC_EN.
- Defined:
  - ERROR lasts exactly one cycle, then goes unconditionally to HUNT.
  - The sample taken while in ERROR is ignored.
  - Re-lock then follows the normal HUNT rules.
- Undefined:
  - ERROR is terminal; sync=0, err=0, expected held, counters frozen regardless of Q.
  - Only R leaves ERROR.

Test Plan:
1. Lap count: R=1 for 2 edges, then drive Q=0,2,5,7,8,11,13,14,0
   - sync=1 from the edge after 0, expected=2 then 5...
   - laps=1 after 14 is accepted; err stays 0.
2. Mid-sequence lock: after reset drive Q=7,8,11 -> sync=1 after 7, expected=8 then 11 then 13; errors=0.
3. Non-members in HUNT: after reset drive Q=1,3,4,15 -> sync=0, err=0, errors=0, expected=SEQ[0]=0.
4. Mismatch: lock on 0, then drive 2, then 6 (expected 5)
   - err=1 for one cycle, errors=1, sync=0.
   - Macro undefined: further 0,2,5 keep sync=0.
   - Macro defined: HUNT after one cycle, re-locks on a valid value.
5. Saturation (macro defined): alternate lock/mismatch pattern producing 300 mismatches -> errors=255 and holds; err still pulses on each mismatch.
6. Reset mid-operation: locked with laps=3, errors=2, assert R for one edge -> sync=0, err=0, expected=0, laps=0, errors=0, state HUNT.
